// File: rtl/ontransit_pkg.sv
// Shared state encoding for the qualified on-transition go/stop channels.
package ontransit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ON     = 2'd2,
    DISARM = 2'd3
  } state_t;

  function automatic logic is_active(state_t st);
    return (st == ON) || (st == DISARM);
  endfunction

endpackage

// File: rtl/ontransit_chan.sv
// One channel: qualifies do_req for QUAL_ON/QUAL_OFF cycles and emits registered
// go/stop strobes, an active level and a saturating go-event counter.
module ontransit_chan
  import ontransit_pkg::*;
#(
  parameter int QUAL_ON  = 3,
  parameter int QUAL_OFF = 2,
  parameter int QW       = 4,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          do_req,
  input  logic          cnt_clr,
  output logic          g,
  output logic          s,
  output logic          active,
  output logic [CW-1:0] go_cnt,
  output logic [1:0]    state
);

  localparam logic [QW-1:0] ON_LAST  = QW'(QUAL_ON - 1);
  localparam logic [QW-1:0] OFF_LAST = QW'(QUAL_OFF - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state_q, state_n;
  logic [QW-1:0] qcnt_q, qcnt_n;
  logic          g_n, s_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      g       <= 1'b0;
      s       <= 1'b0;
      active  <= 1'b0;
    end else begin
      state_q <= state_n;
      qcnt_q  <= qcnt_n;
      g       <= g_n;
      s       <= s_n;
      active  <= is_active(state_n);
    end
  end

  always_comb begin
    state_n = state_q;
    qcnt_n  = qcnt_q;
    g_n     = 1'b0;
    s_n     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (do_req) begin
          state_n = ARM;
          qcnt_n  = '0;
        end
      end
      ARM: begin
        if (!do_req) begin
          state_n = IDLE;
        end else if (qcnt_q == ON_LAST) begin
          state_n = ON;
          g_n     = 1'b1;
        end else begin
          qcnt_n = qcnt_q + QW'(1);
        end
      end
      ON: begin
        if (!do_req) begin
          state_n = DISARM;
          qcnt_n  = '0;
        end
      end
      DISARM: begin
        // A request returning during the off-hold is a dropout, not a new go.
        if (do_req) begin
          state_n = ON;
        end else if (qcnt_q == OFF_LAST) begin
          state_n = IDLE;
          s_n     = 1'b1;
        end else begin
          qcnt_n = qcnt_q + QW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A clear coinciding with a go keeps that go as the first counted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      go_cnt <= '0;
    end else if (cnt_clr) begin
      go_cnt <= g_n ? CW'(1) : '0;
    end else if (g_n && (go_cnt != CNT_MAX)) begin
      go_cnt <= go_cnt + CW'(1);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ontransit_qual_fsm.sv
// Multi-channel qualified go/stop strobe generator; channels are independent
// instances of ontransit_chan, with per-channel state exposed for debug.
module ontransit_qual_fsm
  import ontransit_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int QUAL_ON  = 3,
  parameter int QUAL_OFF = 2,
  parameter int QW       = 4,
  parameter int CW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    do_req,
  input  logic              cnt_clr,
  output logic [NCH-1:0]    g,
  output logic [NCH-1:0]    s,
  output logic [NCH-1:0]    active,
  output logic [NCH*CW-1:0] go_cnt,
  output logic [NCH*2-1:0]  state
);

  for (genvar i = 0; i < NCH; i++) begin : gen_ch
    ontransit_chan #(
      .QUAL_ON  (QUAL_ON),
      .QUAL_OFF (QUAL_OFF),
      .QW       (QW),
      .CW       (CW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .do_req  (do_req[i]),
      .cnt_clr (cnt_clr),
      .g       (g[i]),
      .s       (s[i]),
      .active  (active[i]),
      .go_cnt  (go_cnt[i*CW +: CW]),
      .state   (state[i*2 +: 2])
    );
  end

endmodule

// File: tb/tb_ontransit_qual_fsm.sv
// Bench for ontransit_qual_fsm: per-edge expected outputs are queued by the
// driver from a run-length reference model and popped by a separate monitor.
module tb_ontransit_qual_fsm;

  localparam int NCH  = 4;
  localparam int QON  = 3;
  localparam int QOFF = 2;
  localparam int CW   = 2;
  localparam int W    = 3*NCH + NCH*CW;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    do_req;
  logic              cnt_clr;
  logic [NCH-1:0]    g, s, active;
  logic [NCH*CW-1:0] go_cnt;
  logic [NCH*2-1:0]  state;

  int check_cnt = 0;
  int err_cnt   = 0;

  logic [W-1:0] exp_q[$];

  // reference model: run length of the "toggling" input level per channel
  int m_on  [NCH];
  int m_run [NCH];
  int m_cnt [NCH];

  ontransit_qual_fsm #(
    .NCH(NCH), .QUAL_ON(QON), .QUAL_OFF(QOFF), .QW(4), .CW(CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .do_req  (do_req),
    .cnt_clr (cnt_clr),
    .g       (g),
    .s       (s),
    .active  (active),
    .go_cnt  (go_cnt),
    .state   (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [NCH-1:0] d, input logic c,
                              output logic [W-1:0] vec);
    logic [NCH-1:0]    eg, es, ea;
    logic [NCH*CW-1:0] ec;
    eg = '0; es = '0; ea = '0; ec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_on[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
      end else begin
        if (m_on[i] == 0) begin
          m_run[i] = d[i] ? m_run[i] + 1 : 0;
          if (m_run[i] == QON + 1) begin
            m_on[i] = 1; m_run[i] = 0; eg[i] = 1'b1;
          end
        end else begin
          m_run[i] = !d[i] ? m_run[i] + 1 : 0;
          if (m_run[i] == QOFF + 1) begin
            m_on[i] = 0; m_run[i] = 0; es[i] = 1'b1;
          end
        end
        if (c) m_cnt[i] = eg[i] ? 1 : 0;
        else if (eg[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i] = m_cnt[i] + 1;
      end
      ea[i] = (m_on[i] != 0);
      ec[i*CW +: CW] = CW'(m_cnt[i]);
    end
    vec = {eg, es, ea, ec};
  endtask

  // driver: one clock edge per call; outputs are settled when it returns
  task automatic step(input logic r, input logic [NCH-1:0] d, input logic c);
    logic [W-1:0] vec;
    @(negedge clk);
    rst = r; do_req = d; cnt_clr = c;
    model_update(r, d, c, vec);
    exp_q.push_back(vec);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input logic [NCH-1:0] d, input int n);
    for (int i = 0; i < n; i++) step(1'b0, d, 1'b0);
  endtask

  // monitor / scoreboard
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_outputs", 32'({g, s, active, go_cnt}), 32'(e));
    end
  end

  initial begin
    rst = 1'b1; do_req = '0; cnt_clr = 1'b0;

    // reset with all requests high
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    chk("rst_g", 32'(g), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_go_cnt", 32'(go_cnt), 0);
    chk("rst_state", 32'(state), 0);
    run(4'hF, 3);
    chk("t1_no_early_g", 32'(g), 0);
    step(1'b0, 4'hF, 1'b0);
    chk("t1_g_4th_edge", 32'(g), 32'hF);
    chk("t1_active", 32'(active), 32'hF);
    run(4'hF, 2);
    chk("t1_g_one_cycle", 32'(g), 0);
    run(4'h0, 2);
    chk("t1_no_early_s", 32'(s), 0);
    step(1'b0, 4'h0, 1'b0);
    chk("t1_s", 32'(s), 32'hF);
    chk("t1_inactive", 32'(active), 0);
    step(1'b0, 4'h0, 1'b1);
    chk("clr_go_cnt", 32'(go_cnt), 0);

    // ch1 qualified go and stop
    run(4'h2, 3);
    chk("t2_no_early_g", 32'(g), 0);
    step(1'b0, 4'h2, 1'b0);
    chk("t2_g1", 32'(g), 32'h2);
    run(4'h2, 6);
    chk("t2_single_g", 32'(g), 0);
    chk("t2_active", 32'(active), 32'h2);
    run(4'h0, 2);
    chk("t2_no_early_s", 32'(s), 0);
    step(1'b0, 4'h0, 1'b0);
    chk("t2_s1", 32'(s), 32'h2);
    chk("t2_go_cnt", 32'(go_cnt), 32'h04);

    // ch2 glitches
    run(4'h4, 2);
    run(4'h0, 2);
    chk("t3_glitch_no_cnt", 32'(go_cnt), 32'h04);
    chk("t3_glitch_inactive", 32'(active), 0);
    run(4'h4, 4);
    chk("t3_g2", 32'(g), 32'h4);
    step(1'b0, 4'h0, 1'b0);
    chk("t3_dropout_active", 32'(active), 32'h4);
    run(4'h4, 3);
    chk("t3_dropout_no_s", 32'(s), 0);
    chk("t3_still_active", 32'(active), 32'h4);
    run(4'h0, 3);
    chk("t3_s2", 32'(s), 32'h4);

    // all channels together
    step(1'b0, 4'h0, 1'b1);
    run(4'hF, 3);
    step(1'b0, 4'hF, 1'b0);
    chk("t4_g_all", 32'(g), 32'hF);
    run(4'h0, 2);
    step(1'b0, 4'h0, 1'b0);
    chk("t4_s_all", 32'(s), 32'hF);
    chk("t4_go_cnt", 32'(go_cnt), 32'h55);

    // ch3 saturation, then clear on a go edge
    step(1'b0, 4'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      run(4'h8, 4);
      run(4'h0, 3);
    end
    chk("t5_saturated", 32'(go_cnt), 32'hC0);
    run(4'h8, 3);
    step(1'b0, 4'h8, 1'b1);
    chk("t5_clr_g", 32'(g), 32'h8);
    chk("t5_clr_keeps_event", 32'(go_cnt), 32'h40);
    run(4'h0, 3);

    // reset while ch0 is disarming
    run(4'h1, 4);
    chk("t6_g0", 32'(g), 32'h1);
    step(1'b0, 4'h0, 1'b0);
    chk("t6_disarm_active", 32'(active), 32'h1);
    chk("t6_disarm_state", 32'(state), 32'h3);
    step(1'b1, 4'h0, 1'b0);
    chk("t6_abort_s", 32'(s), 0);
    chk("t6_abort_active", 32'(active), 0);
    chk("t6_abort_state", 32'(state), 0);
    chk("t6_abort_go_cnt", 32'(go_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'h0, 1'b0);
      chk("t6_no_late_s", 32'(s), 0);
    end
    run(4'h1, 3);
    step(1'b0, 4'h1, 1'b0);
    chk("t6_rearm_g", 32'(g), 32'h1);
    run(4'h0, 3);

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      err_cnt++;
      $display("FAIL sb_drain actual=%0d expected=0 entries left", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
